// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and baud timing helpers shared by the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } rx_state_e;

    function automatic int baud_ticks(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_ticks(input int clk_freq, input int baud_rate);
        return baud_ticks(clk_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO for received bytes
module uart_rx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(Depth);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Pop only when data exists; a push into a full FIFO lands only if a pop frees a slot
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Pointer and occupancy state, flushed by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, noise rejection and a receive FIFO
module uart_rx import uart_pkg::*; #(
    parameter int         ClkFreq      = 50_000_000,
    parameter int         BaudRate     = 115200,
    parameter int         RXBuferDepth = 32,
    parameter logic [7:0] EosChar      = 8'h0A
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       eos_flag,
    output logic       buffer_full,
    input  logic       fifo_read,
    output logic [7:0] fifo_data,
    output logic       fifo_empty
);
    localparam int BaudTicks = baud_ticks(ClkFreq, BaudRate);
    localparam int HalfTicks = half_ticks(ClkFreq, BaudRate);
    localparam int CW        = $clog2(BaudTicks);

    rx_state_e     state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d, eos_q, eos_d;
    logic          wait_high_q, wait_high_d;
    logic          baud_tick, half_tick;

    assign baud_tick = cnt_q == CW'(BaudTicks - 1);
    assign half_tick = cnt_q == CW'(HalfTicks - 1);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign eos_flag  = eos_q;

    // Frame FSM: the counter restarts on every state change so sampling stays mid-bit
    always_comb begin
        state_d     = state_q;
        cnt_d       = baud_tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        eos_d       = 1'b0;
        wait_high_d = wait_high_q && !rx_s_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q && !wait_high_q) state_d = START_BIT;
            end
            START_BIT: begin
                if (half_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (baud_tick) begin
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        eos_d      = shift_q == EosChar;
                    end else begin
                        // A low stop bit must not be mistaken for the next start edge
                        wait_high_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser and FSM state; reset aborts any frame in flight
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            eos_q       <= 1'b0;
            wait_high_q <= 1'b0;
        end else begin
            sync1_q     <= rx_in;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            eos_q       <= eos_d;
            wait_high_q <= wait_high_d;
        end
    end

    uart_rx_fifo #(
        .Width(8),
        .Depth(RXBuferDepth)
    ) u_fifo (
        .clk      (clk_50mhz),
        .rst_n    (rst_n),
        .push     (rx_valid_q),
        .push_data(rx_data_q),
        .pop      (fifo_read),
        .head     (fifo_data),
        .empty    (fifo_empty),
        .full     (buffer_full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames checked every cycle against a frame/queue level model
module tb_uart_rx;
    localparam int         CLK_FREQ = 50_000_000;
    localparam int         BAUD     = 2_500_000;
    localparam int         DEPTH    = 32;
    localparam logic [7:0] EOS      = 8'h0A;
    localparam int         B        = CLK_FREQ / BAUD;
    localparam int         H        = B / 2;
    localparam int         LAT      = 9 * B + H + 3;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_in     = 1'b1;
    logic       fifo_read = 1'b0;
    logic [7:0] rx_data, fifo_data;
    logic       rx_valid, eos_flag, buffer_full, fifo_empty;

    uart_rx #(
        .ClkFreq     (CLK_FREQ),
        .BaudRate    (BAUD),
        .RXBuferDepth(DEPTH),
        .EosChar     (EOS)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .eos_flag   (eos_flag),
        .buffer_full(buffer_full),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int cyc = 0;
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: expected strobe cycles come from the frame start time plus the fixed latency
    int         ev_cyc[$];
    logic [7:0] ev_byte[$];
    logic [7:0] mq[$];
    logic [7:0] last = '0;
    logic [7:0] push_byte = '0;
    logic       push_pend = 1'b0;
    logic       pop_pend = 1'b0;
    logic       exp_v;
    logic       prev_v = 1'b0;
    int         last_rise = 0;
    int         eos_cnt = 0;
    int         start_cyc = 0;

    always @(negedge clk_50mhz) begin
        if (!rst_n) begin
            mq.delete();
            ev_cyc.delete();
            ev_byte.delete();
            last      = '0;
            push_pend = 1'b0;
            pop_pend  = 1'b0;
            prev_v    = 1'b0;
            chk("rst_rx_valid", 32'(rx_valid), 32'd0);
            chk("rst_eos", 32'(eos_flag), 32'd0);
            chk("rst_rx_data", 32'(rx_data), 32'd0);
            chk("rst_empty", 32'(fifo_empty), 32'd1);
            chk("rst_full", 32'(buffer_full), 32'd0);
            chk("rst_fifo_data", 32'(fifo_data), 32'd0);
        end else begin
            if (pop_pend) void'(mq.pop_front());
            if (push_pend && mq.size() < DEPTH) mq.push_back(push_byte);
            while (ev_cyc.size() > 0 && ev_cyc[0] < cyc) begin
                void'(ev_cyc.pop_front());
                void'(ev_byte.pop_front());
            end
            exp_v = ev_cyc.size() > 0 && ev_cyc[0] == cyc;
            if (exp_v) begin
                last = ev_byte[0];
                void'(ev_cyc.pop_front());
                void'(ev_byte.pop_front());
            end
            chk("rx_valid", 32'(rx_valid), 32'(exp_v));
            chk("eos_flag", 32'(eos_flag), 32'(exp_v && last == EOS));
            chk("rx_data", 32'(rx_data), 32'(last));
            chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("buffer_full", 32'(buffer_full), 32'(mq.size() == DEPTH));
            chk("fifo_data", 32'(fifo_data), 32'(mq.size() > 0 ? mq[0] : 8'h00));
            push_pend = exp_v;
            push_byte = last;
            pop_pend  = fifo_read && mq.size() > 0;
            if (rx_valid && !prev_v) last_rise = cyc;
            if (eos_flag) eos_cnt++;
            prev_v = rx_valid;
        end
    end

    task automatic hold(input logic v);
        rx_in = v;
        repeat (B) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(posedge clk_50mhz);
        #1;
        start_cyc = cyc;
        if (stop) begin
            ev_cyc.push_back(cyc + LAT);
            ev_byte.push_back(b);
        end
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
        hold(stop);
        rx_in = 1'b1;
    endtask

    task automatic pop1;
        fifo_read = 1'b1;
        @(posedge clk_50mhz);
        #1;
        fifo_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    initial begin
        idle(10);
        rst_n = 1'b1;
        idle(20);
        chk("idle_empty", 32'(fifo_empty), 32'd1);

        send(8'hAA, 1'b1);
        chk("lat_aa", 32'(last_rise - start_cyc), 32'd193);
        chk("aa_data", 32'(rx_data), 32'hAA);
        chk("aa_head", 32'(fifo_data), 32'hAA);
        chk("aa_eos_cnt", 32'(eos_cnt), 32'd0);
        idle(5);

        @(posedge clk_50mhz);
        #1;
        rx_in = 1'b0;
        idle(5);
        rx_in = 1'b1;
        idle(3 * B);
        chk("glitch_data", 32'(rx_data), 32'hAA);
        chk("glitch_head", 32'(fifo_data), 32'hAA);

        send(8'h0A, 1'b1);
        chk("eos_cnt", 32'(eos_cnt), 32'd1);
        chk("eos_data", 32'(rx_data), 32'h0A);
        chk("pop_aa", 32'(fifo_data), 32'hAA);
        pop1();
        chk("pop_0a", 32'(fifo_data), 32'h0A);
        pop1();
        chk("drained", 32'(fifo_empty), 32'd1);
        pop1();

        send(8'h55, 1'b0);
        idle(2 * B);
        chk("frame_err_data", 32'(rx_data), 32'h0A);
        chk("frame_err_empty", 32'(fifo_empty), 32'd1);

        for (int i = 0; i <= 32; i++) begin
            send(8'(i), 1'b1);
            if (i == 30) chk("not_full_31", 32'(buffer_full), 32'd0);
            if (i == 31) chk("full_32", 32'(buffer_full), 32'd1);
        end
        idle(3);
        chk("full_33", 32'(buffer_full), 32'd1);
        chk("last_rx_33", 32'(rx_data), 32'h20);
        for (int k = 0; k < 32; k++) begin
            chk("drain_order", 32'(fifo_data), 32'(k));
            pop1();
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        idle(3);
        chk("three_head", 32'(fifo_data), 32'h11);
        @(posedge clk_50mhz);
        #1;
        rx_in = 1'b0;
        idle(B);
        rx_in = 1'b1;
        idle(5);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2 * B);
        chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rst_data", 32'(rx_data), 32'd0);

        send(8'hC3, 1'b1);
        idle(3);
        chk("post_rst_data", 32'(rx_data), 32'hC3);
        chk("post_rst_head", 32'(fifo_data), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
